// File: rtl/rom_pkg.sv
// Shared definitions for the ROM burst arbiter: widths, FSM encoding and
// the fixed table contents of the 8x16 constant ROM.
package rom_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [DATA_W-1:0] ROM_TABLE [DEPTH] = '{
    16'habcd, 16'h79ca, 16'h1358, 16'h976a,
    16'h84ad, 16'hd3f5, 16'hf4a2, 16'hc0d1
  };

  // Table lookup kept in one place so the ROM model and any future user agree.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
    return ROM_TABLE[addr];
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/grant/data bundle between the two table consumers (master side)
// and the ROM arbiter (slave side).
interface rom_arbiter_if #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W
);

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] start0;
  logic [ADDR_W-1:0] start1;
  logic [ADDR_W-1:0] len0;
  logic [ADDR_W-1:0] len1;
  logic              gnt0;
  logic              gnt1;
  logic              dvalid0;
  logic              dvalid1;
  logic              last0;
  logic              last1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, start0, start1, len0, len1,
    input  gnt0, gnt1, dvalid0, dvalid1, last0, last1, rdata, busy
  );

  modport slave (
    input  req0, req1, start0, start1, len0, len1,
    output gnt0, gnt1, dvalid0, dvalid1, last0, last1, rdata, busy
  );

endinterface

// File: rtl/rom8x16.sv
// 8-word x 16-bit constant ROM with a registered read port (1-cycle latency).
module rom8x16
  import rom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_q;

  // Output register: loads the addressed word when enabled, cleared by reset.
  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= rom_word(i_addr);
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin burst arbiter sharing one 8x16 ROM between two requesters.
// Arbitrates in IDLE and DRAIN, streams addresses in ISSUE and tags the
// ROM's registered output with per-requester valid/last flags.
module rom_arbiter
  import rom_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_owner;       // requester currently being served
  logic              r_last_owner;  // round-robin pointer: last requester served
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_dvalid0;
  logic              r_dvalid1;
  logic              r_last0;
  logic              r_last1;

  logic              w_arb_slot;
  logic              w_win_valid;
  logic              w_win;
  logic              w_issue;
  logic              w_final;
  logic [DATA_W-1:0] w_rom_q;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_arb_slot  = (r_state == IDLE) || (r_state == DRAIN);
    w_win_valid = w_arb_slot && (bus.req0 || bus.req1);
    w_win       = (bus.req0 && bus.req1) ? ~r_last_owner : bus.req1;
    w_issue     = (r_state == ISSUE);
    w_final     = w_issue && (r_remaining == '0);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: a winner always starts a burst; a finished burst drains one cycle.
  // NOTE: the default assignment first means every path drives w_next_state,
  // so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_win_valid) w_next_state = ISSUE;
      ISSUE: if (w_final)     w_next_state = DRAIN;
      DRAIN: w_next_state = w_win_valid ? ISSUE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Burst bookkeeping: latch the winner's request on grant, then walk the addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
    end else begin
      r_gnt0 <= w_win_valid && !w_win;
      r_gnt1 <= w_win_valid && w_win;
      if (w_win_valid) begin
        r_owner      <= w_win;
        r_last_owner <= w_win;
        r_cur_addr   <= w_win ? bus.start1 : bus.start0;
        r_remaining  <= w_win ? bus.len1 : bus.len0;
      end else if (w_issue) begin
        r_cur_addr  <= r_cur_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // Valid/last tags delayed one cycle to line up with the ROM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvalid0 <= 1'b0;
      r_dvalid1 <= 1'b0;
      r_last0   <= 1'b0;
      r_last1   <= 1'b0;
    end else begin
      r_dvalid0 <= w_issue && !r_owner;
      r_dvalid1 <= w_issue && r_owner;
      r_last0   <= w_final && !r_owner;
      r_last1   <= w_final && r_owner;
    end
  end

  rom8x16 u_rom (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_issue),
    .i_addr  (r_cur_addr),
    .o_rdata (w_rom_q)
  );

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.dvalid0 = r_dvalid0;
  assign bus.dvalid1 = r_dvalid1;
  assign bus.last0   = r_last0;
  assign bus.last1   = r_last1;
  assign bus.rdata   = w_rom_q;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a burst-level schedule model predicts every output
// per cycle, and directed scenarios pin the model with literal expectations.
module tb_rom_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rom_arbiter_if bus_if ();

  rom_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- burst schedule model ----------------
  typedef struct packed {
    logic        dv0;
    logic        dv1;
    logic        l0;
    logic        l1;
    logic [15:0] d;
  } word_t;

  logic [15:0] rom_t [8];
  bit          exp_g0   [int];
  bit          exp_g1   [int];
  bit          exp_busy [int];
  word_t       exp_w    [int];
  int          cyc      = 0;
  int          next_arb = 0;  // first cycle whose inputs may win a grant
  bit          m_last   = 1'b1;

  task automatic model_step();
    bit    win;
    int    s;
    int    l;
    word_t w;
    cyc++;
    if (rst) begin
      exp_g0.delete();
      exp_g1.delete();
      exp_busy.delete();
      exp_w.delete();
      next_arb = cyc;
      m_last   = 1'b1;
    end else if ((cyc - 1) >= next_arb && (bus_if.req0 || bus_if.req1)) begin
      win = (bus_if.req0 && bus_if.req1) ? !m_last : bus_if.req1;
      s   = win ? int'(bus_if.start1) : int'(bus_if.start0);
      l   = win ? int'(bus_if.len1) : int'(bus_if.len0);
      if (win) exp_g1[cyc] = 1'b1;
      else     exp_g0[cyc] = 1'b1;
      for (int k = 0; k <= l; k++) begin
        w     = '0;
        w.dv0 = !win;
        w.dv1 = win;
        w.l0  = !win && (k == l);
        w.l1  = win && (k == l);
        w.d   = rom_t[(s + k) % 8];
        exp_w[cyc + 1 + k] = w;
      end
      for (int k = 0; k <= l + 1; k++) exp_busy[cyc + k] = 1'b1;
      next_arb = cyc + 1 + l;
      m_last   = win;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle comparator ----------------
  initial forever begin
    word_t w;
    bit    g0;
    bit    g1;
    bit    b;
    @(negedge clk);
    if (cyc > 0) begin
      w  = '0;
      g0 = 1'b0;
      g1 = 1'b0;
      b  = 1'b0;
      if (!rst) begin
        if (exp_w.exists(cyc)) w = exp_w[cyc];
        g0 = exp_g0.exists(cyc);
        g1 = exp_g1.exists(cyc);
        b  = exp_busy.exists(cyc);
      end
      check($sformatf("gnt0@%0d", cyc), 32'(bus_if.gnt0), 32'(g0));
      check($sformatf("gnt1@%0d", cyc), 32'(bus_if.gnt1), 32'(g1));
      check($sformatf("dvalid0@%0d", cyc), 32'(bus_if.dvalid0), 32'(w.dv0));
      check($sformatf("dvalid1@%0d", cyc), 32'(bus_if.dvalid1), 32'(w.dv1));
      check($sformatf("last0@%0d", cyc), 32'(bus_if.last0), 32'(w.l0));
      check($sformatf("last1@%0d", cyc), 32'(bus_if.last1), 32'(w.l1));
      check($sformatf("busy@%0d", cyc), 32'(bus_if.busy), 32'(b));
      if (rst || w.dv0 || w.dv1)
        check($sformatf("rdata@%0d", cyc), 32'(bus_if.rdata), 32'(w.d));
      check($sformatf("gnt_excl@%0d", cyc), 32'(bus_if.gnt0 & bus_if.gnt1), 32'd0);
      check($sformatf("dv_excl@%0d", cyc), 32'(bus_if.dvalid0 & bus_if.dvalid1), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_gnt(input bit who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = who ? bus_if.gnt1 : bus_if.gnt0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !bus_if.busy;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    bit          ok;
    logic [15:0] wrap_exp [4];
    int          g1_at;
    int          d1_at;
    int          n_g;
    int          ord [4];
    int          at  [4];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    rom_t[0] = 16'habcd; rom_t[1] = 16'h79ca; rom_t[2] = 16'h1358; rom_t[3] = 16'h976a;
    rom_t[4] = 16'h84ad; rom_t[5] = 16'hd3f5; rom_t[6] = 16'hf4a2; rom_t[7] = 16'hc0d1;

    rst           = 1'b1;
    bus_if.req0   = 1'b1;
    bus_if.req1   = 1'b0;
    bus_if.start0 = 3'd0;
    bus_if.start1 = 3'd0;
    bus_if.len0   = 3'd0;
    bus_if.len1   = 3'd0;

    // Reset with req0 high: everything quiet, then gnt0 on the 2nd cycle after release.
    repeat (3) @(negedge clk);
    check("rst_flags", {25'd0, bus_if.gnt0, bus_if.gnt1, bus_if.dvalid0, bus_if.dvalid1,
                        bus_if.last0, bus_if.last1, bus_if.busy}, 32'd0);
    check("rst_rdata", 32'(bus_if.rdata), 32'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_gnt0_2nd_cycle", 32'(bus_if.gnt0), 32'd1);
    bus_if.req0 = 1'b0;
    wait_idle(ok);
    check("idle_after_rst_burst", 32'(ok), 32'd1);

    // Single word from address 3.
    bus_if.req0 = 1'b1; bus_if.start0 = 3'd3; bus_if.len0 = 3'd0;
    wait_gnt(1'b0, ok);
    check("single_gnt0", 32'(ok), 32'd1);
    bus_if.req0 = 1'b0; bus_if.start0 = 3'd5; bus_if.len0 = 3'd7;
    @(negedge clk);
    check("single_dv_last", {30'd0, bus_if.dvalid0, bus_if.last0}, 32'd3);
    check("single_rdata", 32'(bus_if.rdata), 32'h976a);
    check("single_busy_mid", 32'(bus_if.busy), 32'd1);
    @(negedge clk);
    check("single_busy_drop", 32'(bus_if.busy), 32'd0);
    check("single_no_dv", 32'(bus_if.dvalid0), 32'd0);

    // Wrap-around burst for requester 1.
    wrap_exp[0] = 16'hf4a2; wrap_exp[1] = 16'hc0d1; wrap_exp[2] = 16'habcd; wrap_exp[3] = 16'h79ca;
    bus_if.req1 = 1'b1; bus_if.start1 = 3'd6; bus_if.len1 = 3'd3;
    wait_gnt(1'b1, ok);
    check("wrap_gnt1", 32'(ok), 32'd1);
    bus_if.req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("wrap_dv1_%0d", k), 32'(bus_if.dvalid1), 32'd1);
      check($sformatf("wrap_rdata_%0d", k), 32'(bus_if.rdata), 32'(wrap_exp[k]));
      check($sformatf("wrap_last1_%0d", k), 32'(bus_if.last1), 32'(k == 3));
    end
    @(negedge clk);
    check("wrap_end_dv1", 32'(bus_if.dvalid1), 32'd0);
    wait_idle(ok);

    // Late request: req1 arrives during requester 0's 8-word burst.
    bus_if.req0 = 1'b1; bus_if.start0 = 3'd0; bus_if.len0 = 3'd7;
    wait_gnt(1'b0, ok);
    check("late_gnt0", 32'(ok), 32'd1);
    bus_if.req0 = 1'b0;
    g1_at = -1;
    d1_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus_if.req1 = 1'b1; bus_if.start1 = 3'd2; bus_if.len1 = 3'd0;
      end
      if (bus_if.gnt1 && g1_at < 0) begin
        g1_at = i;
        bus_if.req1 = 1'b0;
      end
      if (bus_if.dvalid1 && d1_at < 0) d1_at = i;
    end
    check("late_gnt1_in_drain_slot", 32'(g1_at), 32'd9);
    check("late_dv1_start", 32'(d1_at), 32'd10);
    wait_idle(ok);

    // Mid-burst reset on the 3rd word of an 8-word burst.
    bus_if.req0 = 1'b1; bus_if.start0 = 3'd0; bus_if.len0 = 3'd7;
    wait_gnt(1'b0, ok);
    check("midrst_gnt0", 32'(ok), 32'd1);
    bus_if.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("midrst_3rd_word_present", 32'(bus_if.rdata), 32'h1358);
    rst = 1'b1;
    #1;
    check("midrst_outputs_zero", {29'd0, bus_if.dvalid0, bus_if.last0, bus_if.busy}, 32'd0);
    check("midrst_rdata_zero", 32'(bus_if.rdata), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("midrst_quiet_%0d", i), {30'd0, bus_if.dvalid0, bus_if.dvalid1}, 32'd0);
    end

    // Contention: both held from reset, len 1 from address 0.
    @(negedge clk);
    rst = 1'b1;
    bus_if.req0 = 1'b1; bus_if.start0 = 3'd0; bus_if.len0 = 3'd1;
    bus_if.req1 = 1'b1; bus_if.start1 = 3'd0; bus_if.len1 = 3'd1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_g = 0;
    for (int k = 0; k < 4; k++) begin
      ord[k] = 2;
      at[k]  = -100;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((bus_if.gnt0 || bus_if.gnt1) && n_g < 4) begin
        ord[n_g] = int'(bus_if.gnt1);
        at[n_g]  = i;
        n_g++;
        if (n_g == 4) begin
          bus_if.req0 = 1'b0;
          bus_if.req1 = 1'b0;
        end
      end
      if (bus_if.dvalid0) q0.push_back(bus_if.rdata);
      if (bus_if.dvalid1) q1.push_back(bus_if.rdata);
      if (n_g == 4 && !bus_if.busy) break;
    end
    check("cont_grants", 32'(n_g), 32'd4);
    check("cont_first_gnt_2nd_cycle", 32'(at[0]), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("cont_order_%0d", k), 32'(ord[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++)
      check($sformatf("cont_gap_%0d", k), 32'(at[k] - at[k-1]), 32'd3);
    check("cont_q0_size", 32'(q0.size()), 32'd4);
    check("cont_q1_size", 32'(q1.size()), 32'd4);
    for (int k = 0; k < 4 && k < q0.size(); k++)
      check($sformatf("cont_q0_%0d", k), 32'(q0[k]), (k % 2 == 0) ? 32'habcd : 32'h79ca);
    for (int k = 0; k < 4 && k < q1.size(); k++)
      check($sformatf("cont_q1_%0d", k), 32'(q1[k]), (k % 2 == 0) ? 32'habcd : 32'h79ca);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
